// File: rtl/instr_fetch_stage.sv
// Fetch stage: turns accepted PCs into synchronous imem reads and hands
// {instruction, pc} pairs to decode through a 2-entry buffer.
module instr_fetch_stage #(
    parameter int ADDR_W  = 6,
    parameter int INSTR_W = 32,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  pc_in,
    input  logic               pc_valid,
    output logic               pc_ready,
    output logic               imem_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               flush,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [ADDR_W-1:0]  dec_pc,
    output logic [CNT_W-1:0]   fetched_cnt
);

    logic [INSTR_W-1:0] instr_q [2];
    logic [ADDR_W-1:0]  pc_q    [2];

    logic [1:0]        count_q, count_d;
    logic              head_q, head_d;
    logic              tail_q, tail_d;
    logic              inflight_v_q, inflight_v_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic [CNT_W-1:0]  fetched_cnt_q, fetched_cnt_d;

    logic [1:0] occ;
    logic [1:0] occ_after_pop;
    logic       pop;
    logic       ready_int;
    logic       accept_int;
    logic       wr_en;

    assign dec_valid     = (count_q != 2'd0) && !flush;
    assign pop           = dec_valid && dec_ready;
    assign occ           = count_q + {1'b0, inflight_v_q};
    assign occ_after_pop = occ - {1'b0, pop};

    // Credit check counts the in-flight read, so a returning word always
    // finds a free slot; a same-cycle pop frees one credit early.
    assign ready_int  = !flush && (occ_after_pop < 2'd2);
    assign accept_int = pc_valid && ready_int;
    assign wr_en      = inflight_v_q && !flush;

    // Outputs are forced quiet while reset is held; state is frozen then anyway.
    assign pc_ready  = rst && ready_int;
    assign imem_en   = pc_valid && pc_ready;
    assign imem_addr = pc_in;

    assign dec_instr   = instr_q[head_q];
    assign dec_pc      = pc_q[head_q];
    assign fetched_cnt = fetched_cnt_q;

    always_comb begin
        count_d       = count_q;
        head_d        = head_q;
        tail_d        = tail_q;
        inflight_v_d  = 1'b0;
        inflight_pc_d = inflight_pc_q;
        fetched_cnt_d = fetched_cnt_q;

        if (flush) begin
            count_d = 2'd0;
            tail_d  = head_q;
        end else begin
            if (wr_en) begin
                tail_d = ~tail_q;
            end
            if (pop) begin
                head_d = ~head_q;
            end
            count_d      = count_q + {1'b0, wr_en} - {1'b0, pop};
            inflight_v_d = accept_int;
            if (accept_int) begin
                inflight_pc_d = pc_in;
            end
        end

        if (pop) begin
            fetched_cnt_d = fetched_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q       <= 2'd0;
            head_q        <= 1'b0;
            tail_q        <= 1'b0;
            inflight_v_q  <= 1'b0;
            inflight_pc_q <= '0;
            fetched_cnt_q <= '0;
            for (int i = 0; i < 2; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else begin
            count_q       <= count_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            inflight_v_q  <= inflight_v_d;
            inflight_pc_q <= inflight_pc_d;
            fetched_cnt_q <= fetched_cnt_d;
            if (wr_en) begin
                instr_q[tail_q] <= imem_rdata;
                pc_q[tail_q]    <= inflight_pc_q;
            end
        end
    end

endmodule
